segment_display_arbiter: RTL and testbench

SEGMENT_DISPLAY_ARBITER -- requirements
Module: segment_display_arbiter

---
 rtl/segment_display_arbiter.sv | 138 +++++++++++++
 tb/tb_segment_display_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/segment_display_arbiter.sv
// Round-robin arbiter that hands a shared 2x7 segment display to one requester at a time,
// with a fixed hold time per owner and blank gap cycles between owners.
module segment_display_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   data_in,
    output logic [N_REQ-1:0]     grant,
    output logic [7:0]           number,
    output logic                 blank,
    output logic [2:0]           owner
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    LAST_INIT = 3'(N_REQ - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state;
    logic [HW-1:0]    hold_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [2:0]       last_owner;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [N_REQ-1:0] win_grant;
    logic [7:0]       win_byte;
    logic [7:0]       owner_byte;
    logic             owner_req;
    logic             other_req;
    int               cand;

    // Round-robin search starting just after the previous owner, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_owner) + k) % N_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = 3'(cand);
            end
        end
    end

    always_comb begin
        win_grant  = '0;
        win_byte   = 8'h00;
        owner_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_grant[i] = 1'b1;
                win_byte     = data_in[8*i +: 8];
            end
            if (owner == 3'(i)) begin
                owner_byte = data_in[8*i +: 8];
            end
        end
    end

    assign owner_req = |(req & grant);
    assign other_req = |(req & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            number     <= 8'h00;
            blank      <= 1'b1;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            last_owner <= LAST_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= SHOW;
                        grant    <= win_grant;
                        owner    <= win_idx;
                        number   <= win_byte;
                        blank    <= 1'b0;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                SHOW: begin
                    // A sole requester whose hold time expires keeps the display without a gap.
                    if (!owner_req || (hold_cnt == '0 && other_req)) begin
                        state      <= GAP;
                        last_owner <= owner;
                        grant      <= '0;
                        owner      <= '0;
                        number     <= 8'h00;
                        blank      <= 1'b1;
                        gap_cnt    <= GAP_LOAD;
                    end else begin
                        number <= owner_byte;
                        if (hold_cnt == '0) begin
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (|req) begin
                            state    <= SHOW;
                            grant    <= win_grant;
                            owner    <= win_idx;
                            number   <= win_byte;
                            blank    <= 1'b0;
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_display_arbiter.sv
// Directed bench for segment_display_arbiter with N_REQ=4, HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_segment_display_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] data_in = 32'h0;
    logic [3:0]  grant;
    logic [7:0]  number;
    logic        blank;
    logic [2:0]  owner;

    int checks = 0;
    int errors = 0;

    segment_display_arbiter #(
        .N_REQ(4),
        .HOLD_CYCLES(4),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .data_in(data_in),
        .grant(grant),
        .number(number),
        .blank(blank),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [2:0] o,
                             input logic [7:0] n, input logic b);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".owner"}, 32'(owner), 32'(o));
        check({tag, ".number"}, 32'(number), 32'(n));
        check({tag, ".blank"}, 32'(blank), 32'(b));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic to_idle(input string tag);
        req = 4'b0000;
        repeat (3) cyc();
        check_out(tag, 4'b0000, 3'd0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [3:0] g;
        int o;

        #1 rst_n = 1'b0;
        #1 check_out("reset", 4'b0000, 3'd0, 8'h00, 1'b1);
        cyc();
        rst_n = 1'b1;

        // Rotation with all requesters active
        req = 4'b1111;
        data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int r = 0; r < 5; r++) begin
            o = r % 4;
            g = 4'b0001 << o;
            for (int c = 0; c < 4; c++) begin
                cyc();
                check_out($sformatf("rot%0d_show%0d", r, c), g, 3'(o), 8'hA0 + 8'(o), 1'b0);
            end
            if (r < 4) begin
                for (int c = 0; c < 2; c++) begin
                    cyc();
                    check_out($sformatf("rot%0d_gap%0d", r, c), 4'b0000, 3'd0, 8'h00, 1'b1);
                end
            end
        end
        to_idle("rot_idle");

        // Single requester is re-granted without gaps
        req = 4'b0001;
        data_in = {8'h00, 8'h00, 8'h00, 8'h3C};
        for (int c = 0; c < 12; c++) begin
            cyc();
            check_out($sformatf("single%0d", c), 4'b0001, 3'd0, 8'h3C, 1'b0);
        end
        to_idle("single_idle");

        // Live data update while showing
        req = 4'b0010;
        data_in = {8'h00, 8'h00, 8'h12, 8'h00};
        cyc();
        check_out("live0", 4'b0010, 3'd1, 8'h12, 1'b0);
        cyc();
        data_in = {8'h00, 8'h00, 8'hAB, 8'h00};
        cyc();
        check_out("live1", 4'b0010, 3'd1, 8'hAB, 1'b0);
        to_idle("live_idle");

        // Early release by owner 2, then requester 3 takes over after the gap
        req = 4'b1100;
        data_in = {8'h5A, 8'hC2, 8'h00, 8'h00};
        cyc();
        check_out("early_show", 4'b0100, 3'd2, 8'hC2, 1'b0);
        req = 4'b1000;
        cyc();
        check_out("early_gap0", 4'b0000, 3'd0, 8'h00, 1'b1);
        cyc();
        check_out("early_gap1", 4'b0000, 3'd0, 8'h00, 1'b1);
        cyc();
        check_out("early_next", 4'b1000, 3'd3, 8'h5A, 1'b0);
        to_idle("early_idle");

        // One-cycle pulse on requester 1
        req = 4'b0010;
        data_in = {8'h00, 8'h77, 8'h61, 8'h00};
        cyc();
        check_out("pulse_show", 4'b0010, 3'd1, 8'h61, 1'b0);
        req = 4'b0000;
        cyc();
        check_out("pulse_gap0", 4'b0000, 3'd0, 8'h00, 1'b1);
        cyc();
        check_out("pulse_gap1", 4'b0000, 3'd0, 8'h00, 1'b1);
        cyc();
        check_out("pulse_idle", 4'b0000, 3'd0, 8'h00, 1'b1);
        req = 4'b0100;
        cyc();
        check_out("idle_regrant", 4'b0100, 3'd2, 8'h77, 1'b0);

        // Asynchronous reset while requester 2 owns the display
        req = 4'b1111;
        data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", 4'b0000, 3'd0, 8'h00, 1'b1);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_out("post_reset", 4'b0001, 3'd0, 8'hA0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
